// File: rtl/move_exec_ctrl.sv
// move_exec_ctrl: executes MOVE (rd <- rs) and MOVI (rd <- imm) against a
// register file with a 1-cycle synchronous read. Reports busy, a one-cycle
// done pulse, and a one-cycle err pulse when both starts arrive together.
//
// Build option: define MOVI_SIGN_EXT_EN to sign-extend the MOVI immediate
// from bit IMM_W-1; otherwise the immediate is zero-extended.
module move_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_move,
  input  logic              start_movi,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              armed;       // a start may be accepted
  logic [ADDR_W-1:0] rd_q;        // destination latched at accept
  logic [DATA_W-1:0] imm_data;    // extended immediate latched at accept
  logic              wr_from_rf;  // current write takes its data from the RF read port

  // Immediate extension to the register width, selected at build time.
  function automatic logic [DATA_W-1:0] form_imm(input logic [IMM_W-1:0] imm);
`ifdef MOVI_SIGN_EXT_EN
    return DATA_W'($signed(imm));
`else
    return DATA_W'(imm);
`endif
  endfunction

  // The read data only becomes valid in the cycle after rf_rd_en, which is
  // the write cycle itself, so a MOVE forwards the read port straight to the
  // write port for that one cycle. Every other cycle the value is registered.
  assign rf_wr_data = wr_from_rf ? rf_rd_data : imm_data;

  // Sequencer: accept/arming, per-state registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every control and output register is reset here so that an
      // in-flight operation is dropped cleanly; there is no storage array.
      state      <= IDLE;
      armed      <= 1'b1;
      rd_q       <= '0;
      imm_data   <= '0;
      wr_from_rf <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // register values from before this edge and defaults can be overridden.
      rf_rd_en   <= 1'b0;
      rf_wr_en   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_from_rf <= 1'b0;

      case (state)
        IDLE: begin
          if (!start_move && !start_movi) begin
            // A quiet idle cycle re-arms; a held strobe never re-fires.
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            rd_q  <= instr_rd;
            if (start_move && start_movi) begin
              err <= 1'b1;
            end else if (start_move) begin
              state      <= READ;
              busy       <= 1'b1;
              rf_rd_en   <= 1'b1;
              rf_rd_addr <= instr_rs;
            end else begin
              state      <= WRITE;
              busy       <= 1'b1;
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= instr_rd;
              imm_data   <= form_imm(instr_imm);
            end
          end
        end

        READ: begin
          state      <= WRITE;
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= rd_q;
          wr_from_rf <= 1'b1;
        end

        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_exec_ctrl.sv
// tb_move_exec_ctrl: directed stimulus for move_exec_ctrl with a small
// register-file responder and a transaction-schedule reference model.
module tb_move_exec_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int IMM_W  = 8;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_move = 1'b0;
  logic              start_movi = 1'b0;
  logic [ADDR_W-1:0] instr_rd = '0;
  logic [ADDR_W-1:0] instr_rs = '0;
  logic [IMM_W-1:0]  instr_imm = '0;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data = '0;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  move_exec_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst),
    .start_move(start_move), .start_movi(start_movi),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file responder: 1-cycle synchronous read, synchronous write.
  logic [DATA_W-1:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
    if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
  end

  // Reference model: on every accept it writes the whole future of the
  // operation into a per-cycle schedule of expected outputs.
  typedef struct {
    bit                rd_en;
    bit                wr_en;
    bit                done;
    bit                err;
    bit                busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
  } exp_t;

  exp_t              sched [DEPTH];
  logic [DATA_W-1:0] mdl_mem [16];
  int                cyc = 0;        // cycle index: outputs after edge n are cycle n
  int                idle_from = 0;  // first cycle in which the DUT sits idle
  bit                armed = 1'b1;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
    int v;
    v = int'(imm);
`ifdef MOVI_SIGN_EXT_EN
    if (v >= 128) v = v + 32'hFF00;
`endif
    return v[DATA_W-1:0];
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < DEPTH - 4) begin
      // A write seen in the previous cycle is committed at this edge.
      if (sched[cyc-1].wr_en) mdl_mem[sched[cyc-1].wr_addr] = sched[cyc-1].wr_data;
      if (rst) begin
        for (int k = cyc; k < DEPTH; k++) sched[k] = '{default: '0};
        armed     = 1'b1;
        idle_from = cyc;
      end else if (cyc - 1 >= idle_from) begin
        if (!start_move && !start_movi) begin
          armed = 1'b1;
        end else if (armed) begin
          armed = 1'b0;
          if (start_move && start_movi) begin
            sched[cyc].err = 1'b1;
          end else if (start_move) begin
            sched[cyc].rd_en     = 1'b1;
            sched[cyc].rd_addr   = instr_rs;
            sched[cyc+1].wr_en   = 1'b1;
            sched[cyc+1].wr_addr = instr_rd;
            sched[cyc+1].wr_data = mdl_mem[instr_rs];
            sched[cyc+2].done    = 1'b1;
            for (int k = 0; k < 3; k++) sched[cyc+k].busy = 1'b1;
            idle_from = cyc + 3;
          end else begin
            sched[cyc].wr_en     = 1'b1;
            sched[cyc].wr_addr   = instr_rd;
            sched[cyc].wr_data   = ext_imm(instr_imm);
            sched[cyc+1].done    = 1'b1;
            for (int k = 0; k < 2; k++) sched[cyc+k].busy = 1'b1;
            idle_from = cyc + 2;
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < DEPTH) begin
      check("rf_rd_en", 32'(rf_rd_en), 32'(sched[cyc].rd_en));
      check("rf_wr_en", 32'(rf_wr_en), 32'(sched[cyc].wr_en));
      check("done",     32'(done),     32'(sched[cyc].done));
      check("err",      32'(err),      32'(sched[cyc].err));
      check("busy",     32'(busy),     32'(sched[cyc].busy));
      if (sched[cyc].rd_en) check("rf_rd_addr", 32'(rf_rd_addr), 32'(sched[cyc].rd_addr));
      if (sched[cyc].wr_en) begin
        check("rf_wr_addr", 32'(rf_wr_addr), 32'(sched[cyc].wr_addr));
        check("rf_wr_data", 32'(rf_wr_data), 32'(sched[cyc].wr_data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit                is_move;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [IMM_W-1:0]  imm;
  } op_t;

  op_t ops [4];
  int  n_rd, n_wr, n_done;

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 16'(16'h1000 + i * 16'h0111);
      mdl_mem[i] = 16'(16'h1000 + i * 16'h0111);
    end
    rf_mem[7]  = 16'hBEEF;
    mdl_mem[7] = 16'hBEEF;

    // Reset state.
    step(2);
    check("reset_busy",    32'(busy),       32'd0);
    check("reset_rd_addr", 32'(rf_rd_addr), 32'd0);
    check("reset_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("reset_wr_data", 32'(rf_wr_data), 32'd0);
    rst = 1'b0;
    step(1);

    // MOVI rd=3 imm=0x85, one-cycle strobe.
    instr_rd = 4'd3; instr_imm = 8'h85; start_movi = 1'b1;
    step(1);
    start_movi = 1'b0; instr_rd = 4'd9; instr_imm = 8'h11;
    check("movi_wr_en",   32'(rf_wr_en),   32'd1);
    check("movi_wr_addr", 32'(rf_wr_addr), 32'd3);
`ifdef MOVI_SIGN_EXT_EN
    check("movi_wr_data", 32'(rf_wr_data), 32'hFF85);
`else
    check("movi_wr_data", 32'(rf_wr_data), 32'h0085);
`endif
    check("movi_busy1", 32'(busy), 32'd1);
    step(1);
    check("movi_done",  32'(done), 32'd1);
    check("movi_busy2", 32'(busy), 32'd1);
    step(1);
    check("movi_idle", 32'(busy), 32'd0);
    step(1);

    // MOVE rd=2 rs=7 (RF[7]=0xBEEF).
    instr_rd = 4'd2; instr_rs = 4'd7; start_move = 1'b1;
    step(1);
    start_move = 1'b0;
    check("move_rd_en",   32'(rf_rd_en),   32'd1);
    check("move_rd_addr", 32'(rf_rd_addr), 32'd7);
    step(1);
    check("move_wr_en",   32'(rf_wr_en),   32'd1);
    check("move_wr_addr", 32'(rf_wr_addr), 32'd2);
    check("move_wr_data", 32'(rf_wr_data), 32'hBEEF);
    step(1);
    check("move_done", 32'(done), 32'd1);
    step(2);

    // Held strobe: ten cycles of start_move give exactly one operation.
    instr_rd = 4'd5; instr_rs = 4'd2; start_move = 1'b1;
    n_rd = 0; n_wr = 0; n_done = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_rd   += int'(rf_rd_en);
      n_wr   += int'(rf_wr_en);
      n_done += int'(done);
    end
    check("held_reads",  32'(n_rd),   32'd1);
    check("held_writes", 32'(n_wr),   32'd1);
    check("held_dones",  32'(n_done), 32'd1);
    start_move = 1'b0;
    step(1);
    instr_rd = 4'd4; instr_rs = 4'd3; start_move = 1'b1;
    step(1);
    start_move = 1'b0;
    check("rearm_rd_en", 32'(rf_rd_en), 32'd1);
    step(4);

    // Illegal: both starts together.
    start_move = 1'b1; start_movi = 1'b1; instr_rd = 4'd1;
    step(1);
    start_move = 1'b0; start_movi = 1'b0;
    check("illegal_err",  32'(err),  32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    step(1);
    check("illegal_err_pulse", 32'(err), 32'd0);
    step(2);

    // Start while busy: MOVE rd=6 rs=1, then MOVI strobe and new fields during WRITE.
    instr_rd = 4'd6; instr_rs = 4'd1; start_move = 1'b1;
    step(1);
    start_move = 1'b0; instr_rd = 4'd9; instr_rs = 4'd0;
    step(1);
    start_movi = 1'b1; instr_imm = 8'h11;
    check("busy_wr_addr", 32'(rf_wr_addr), 32'd6);
    check("busy_wr_data", 32'(rf_wr_data), 32'h1111);
    step(1);
    start_movi = 1'b0;
    step(3);

    // Reset during READ of a MOVE, then a normal MOVI.
    instr_rd = 4'd8; instr_rs = 4'd7; start_move = 1'b1;
    step(1);
    start_move = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_wr_en", 32'(rf_wr_en), 32'd0);
    check("abort_busy",  32'(busy),     32'd0);
    check("abort_done",  32'(done),     32'd0);
    step(1);
    instr_rd = 4'd10; instr_imm = 8'hF0; start_movi = 1'b1;
    step(1);
    start_movi = 1'b0;
    check("post_abort_wr_addr", 32'(rf_wr_addr), 32'd10);
    step(3);

    // Back-to-back at minimum issue interval (MOVE 5, MOVI 4), incl. rd==rs.
    ops[0] = '{is_move: 1'b1, rd: 4'd12, rs: 4'd10, imm: 8'h00};
    ops[1] = '{is_move: 1'b0, rd: 4'd13, rs: 4'd0,  imm: 8'h7F};
    ops[2] = '{is_move: 1'b1, rd: 4'd7,  rs: 4'd7,  imm: 8'h00};
    ops[3] = '{is_move: 1'b0, rd: 4'd14, rs: 4'd0,  imm: 8'hFF};
    foreach (ops[i]) begin
      instr_rd = ops[i].rd; instr_rs = ops[i].rs; instr_imm = ops[i].imm;
      if (ops[i].is_move) start_move = 1'b1; else start_movi = 1'b1;
      step(1);
      start_move = 1'b0; start_movi = 1'b0;
      step(ops[i].is_move ? 4 : 3);
    end
    step(3);
    check("final_rf7",  32'(rf_mem[7]),  32'hBEEF);
`ifdef MOVI_SIGN_EXT_EN
    check("final_rf12", 32'(rf_mem[12]), 32'hFFF0);
    check("final_rf14", 32'(rf_mem[14]), 32'hFFFF);
`else
    check("final_rf12", 32'(rf_mem[12]), 32'h00F0);
    check("final_rf14", 32'(rf_mem[14]), 32'h00FF);
`endif
    check("final_rf13", 32'(rf_mem[13]), 32'h007F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
